// File: rtl/countdown_timer.sv
// countdown_timer: loadable synchronous down-counter with start/abort/pause
// control and a one-cycle terminal-count pulse on `done`.
//
// Optional feature: define COUNTDOWN_TIMER_AUTORELOAD_EN to reload the count
// from the last loaded value on every expiry. The block then stays in RUN and
// becomes a periodic tick generator until it sees abort, rst or a new start.
// Without the macro the reload register does not exist, and expiry returns
// the block to IDLE.
//
// Edge priority: rst > abort > start > pause > decrement.

module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
`endif

  // busy is decoded straight from the state flop, so it is still a registered output
  assign busy = (state == RUN);

  // State, count, done pulse and reload value are all flops; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      done   <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload <= '0;
`endif
    end else begin
      state  <= state_next;
      count  <= count_next;
      done   <= done_next;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload <= reload_next;
`endif
    end
  end

  // Next-state logic: abort beats start, start beats pause, pause beats decrement
  always_comb begin
    state_next  = state;
    count_next  = count;
    done_next   = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_next = reload;
`endif

    if (abort) begin
      count_next = '0;
      state_next = IDLE;
    end else if (start) begin
      count_next = load_val;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_next = load_val;
`endif
      if (load_val == '0) begin
        done_next  = 1'b1;
        state_next = IDLE;
      end else begin
        state_next = RUN;
      end
    end else if ((state == RUN) && !pause) begin
      if (count == WIDTH'(1)) begin
        done_next = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        count_next = reload;
`else
        count_next = '0;
        state_next = IDLE;
`endif
      end else if (count != '0) begin
        count_next = count - WIDTH'(1);
      end else begin
        state_next = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: self-checking bench for countdown_timer (WIDTH=8).
// Each scenario builds a table of per-cycle stimulus rows and their expected
// {count, busy, done}. Driving a row pushes its expectation onto a scoreboard
// queue, and after the clock edge the scenario pops the entry and compares it.
// Expectations follow the documented timing. Scenarios that reach expiry use
// term_exp(), which gives the expiry value for the build (with or without
// COUNTDOWN_TIMER_AUTORELOAD_EN).

module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             b;
    logic             d;
  } exp_t;

  typedef struct {
    logic             r;
    logic             s;
    logic [WIDTH-1:0] lv;
    logic             p;
    logic             a;
    exp_t             e;
  } row_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input int c, input bit b, input bit d);
    exp_t e;
    e.c = WIDTH'(c);
    e.b = b;
    e.d = d;
    return e;
  endfunction

  // Expected outputs just after the terminal decrement of an interval of length n
  function automatic exp_t term_exp(input int n);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    return ex(n, 1'b1, 1'b1);
`else
    return ex(n - n, 1'b0, 1'b1);
`endif
  endfunction

  function automatic row_t mk(input bit r, input bit s, input int lv,
                              input bit p, input bit a, input exp_t e);
    row_t x;
    x.r  = r;
    x.s  = s;
    x.lv = WIDTH'(lv);
    x.p  = p;
    x.a  = a;
    x.e  = e;
    return x;
  endfunction

  // Drive one row, record its expectation, then move to just after the next edge
  task automatic step(input row_t x);
    rst      = x.r;
    start    = x.s;
    load_val = x.lv;
    pause    = x.p;
    abort    = x.a;
    exp_q.push_back(x.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 8, 0, 0, ex(8, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(7, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(6, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(5, 1, 0)));
    rows.push_back(mk(1, 1, 9, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL reset row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_basic_count();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 4, 0, 0, ex(4, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(3, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(4)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 1, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL basic row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_pause();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 3, 0, 0, ex(3, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 1, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 1, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(3)));
    rows.push_back(mk(0, 1, 5, 1, 0, ex(5, 1, 0)));
    rows.push_back(mk(0, 0, 0, 1, 0, ex(5, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(4, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL pause row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_abort();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 2, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 6, 0, 0, ex(6, 1, 0)));
    rows.push_back(mk(0, 1, 9, 0, 1, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL abort row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_restart();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 10, 0, 0, ex(10, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(9, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(8, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(7, 1, 0)));
    rows.push_back(mk(0, 1, 2, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(2)));
    rows.push_back(mk(0, 1, 5, 0, 0, ex(5, 1, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, ex(0, 0, 1)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL restart row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_zero_load();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 0, 0, ex(0, 0, 1)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 0, 1, 0, ex(0, 0, 1)));
    rows.push_back(mk(0, 1, 0, 0, 0, ex(0, 0, 1)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL zero_load row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

  task automatic test_width_boundary();
    row_t rows[$];
    exp_t e;
    int   done_seen;
    done_seen = 0;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 255, 0, 0, ex(255, 1, 0)));
    for (int k = 254; k >= 1; k--) begin
      rows.push_back(mk(0, 0, 0, 0, 0, ex(k, 1, 0)));
    end
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(255)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      if (done === 1'b1) done_seen++;
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL width row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
    checks++;
    if (done_seen !== 1) begin
      errors++;
      $display("[TB] FAIL width done_count: got %0d pulses, want 1", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 1, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 1, 2, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(2)));
    rows.push_back(mk(0, 1, 1, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, term_exp(1)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 1, 3, 0, 0, ex(3, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(3, 1, 1)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(1, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(3, 1, 1)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(2, 1, 0)));
    rows.push_back(mk(0, 0, 0, 0, 1, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    rows.push_back(mk(0, 0, 0, 0, 0, ex(0, 0, 0)));
    foreach (rows[i]) begin
      step(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ({count, busy, done} !== e) begin
        errors++;
        $display("[TB] FAIL autoreload row %0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 i, count, busy, done, e.c, e.b, e.d);
      end
    end
  endtask
`endif

  // Run every scenario in sequence, then report the totals
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    load_val = '0;
    pause    = 1'b0;
    abort    = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] starting countdown_timer scenarios");
    test_reset();
    test_basic_count();
    test_pause();
    test_abort();
    test_restart();
    test_zero_load();
    test_width_boundary();
    test_back_to_back();
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable synchronous down-counter with start/abort/pause control and a one-cycle terminal-count pulse. It is the decrementing counterpart to the free-running up-counter already in the design. It times fixed-length intervals for control logic: a controller loads a cycle count, the block counts it down, and it signals expiry. Optional auto-reload turns it into a periodic tick generator.

## Interface
- WIDTH, default 8: counter and load-value width in bits (legal range 2..32).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  load `load_val` and begin counting; level-sampled each edge.
- load_val  input  WIDTH  interval length in cycles, unsigned.
- pause  input  1  freeze `count` while in RUN.
- abort  input  1  stop immediately without `done`.
- count  output  WIDTH  current remaining count.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when `count` reaches 0 by decrement.

## Operation
- States: IDLE (busy=0) and RUN (busy=1). State, `count`, `done` and the internal reload register are all flops.
- Reset (rst=1 at an edge):
  - state=IDLE, count=0, done=0, busy=0, reload register=0.
  - Reset overrides every other input, including mid-RUN.
- Per-edge priority: rst > abort > start > pause > decrement.
- `done` defaults to 0 every cycle. It is set only on the terminal decrement or on a zero-length start.
- IDLE:
  - start=1, load_val≠0: count←load_val, reload←load_val, go to RUN.
  - start=1, load_val=0: count←0, done←1, stay IDLE.
  - Otherwise: hold `count`. `pause` has no effect.
- RUN:
  - abort=1: count←0, go to IDLE, done stays 0.
  - start=1: restart. count←load_val, reload←load_val. If load_val=0, done←1 and go to IDLE.
  - pause=1: hold `count`.
  - Otherwise: count←count−1.
  - Terminal decrement: if count=1 and the block decrements, count←0 and done←1.
- No underflow: `count` never wraps below 0. In IDLE, `count` holds its last value.
- abort in IDLE: count←0, no other effect.

## Timing
- `start` with load_val=N (N≥1) sampled at edge E0:
  - after E0: count=N, busy=1.
  - after Ek: count=N−k (absent pause).
  - after EN: count=0, done=1, busy=0.
- Interval is exactly N cycles from first high `busy` to `done`. Each pause cycle extends it by one.
- `done` is high for exactly one cycle per expiry and is never asserted with rst=1.
- Zero-length start: `done` asserts the cycle after the start edge.
- start and pause together: start wins, so the load takes effect and pause is ignored that edge.
- abort at the terminal edge (count=1): abort wins, so no `done`.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTORELOAD_EN`.
- Defined:
  - On the terminal decrement, done←1, count←reload, and the block stays in RUN.
  - Result: periodic `done` every `reload` cycles until abort, rst or a new start.
  - A start with a new load_val replaces the reload value.
- Undefined:
  - Terminal decrement returns to IDLE as described above.
  - The reload register may be optimised away, since it is then unused.

## Test plan
- Reset: drive rst=1 for 2 cycles mid-RUN with count=5 → count=0, busy=0, done=0 on the next cycle.
- Basic count: start with load_val=4 → count 4,3,2,1,0 on successive cycles; done=1 only when count=0; busy falls with done.
- Pause and abort:
  - load_val=3, pause high for 2 cycles after the first decrement → done arrives 5 cycles after the start edge.
  - Separate run: abort at count=1 → count=0, done never asserts.
- Restart and zero:
  - start load_val=10, then start load_val=2 at count=7 → done 2 cycles later.
  - start with load_val=0 in IDLE → done pulse one cycle later, busy stays 0.
- Width boundary: WIDTH=8, load_val=255 → exactly 255 RUN cycles, done once, no wrap.
- Auto-reload (macro defined): load_val=3 → done every 3rd cycle with count sequence 3,2,1,3,2,1…; abort → count=0, busy=0, no further done.
